cdb_arbiter: RTL

//  Common Data Bus arbiter; sits between the functional units and the reorder buffer result port.

---
 rtl/ooo_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/cdb_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared out-of-order core types: result record, ROB tag, default sizes
// Purpose: result record passed from functional units through the CDB to the ROB
//          and reservation stations, plus the default core sizing constants.
package ooo_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ROB_SIZE   = 16;
  localparam int NUM_FU     = 4;
  localparam int ROB_TAG_W  = $clog2(ROB_SIZE);
  localparam int CAUSE_W    = 32;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                  valid;
    rob_tag_t              rob_tag;
    logic [DATA_WIDTH-1:0] data;
    logic                  exception_valid;
    logic [CAUSE_W-1:0]    exception_cause;
  } ooo_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot arbiter
// Purpose: grants the first requester at or above rr_ptr, wrapping N-1 -> 0.
// Ports:
//   req       in  N            request vector
//   rr_ptr    in  $clog2(N)    highest-priority index this cycle
//   grant     out N            one-hot grant, zero when nothing requests
//   grant_idx out $clog2(N)    encoded grant index, zero when nothing requests
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IdxW = $clog2(N);

  logic            found;
  int              pos;
  logic [IdxW-1:0] idx;

  // Explicit subtract-wrap instead of modulo keeps non-power-of-2 N legal.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = IdxW'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter with per-FU one-entry result buffers
// Purpose: collects completed results from NUM_FU functional units, picks one per
//          cycle round-robin and broadcasts it registered on the CDB.
// Ports:
//   clk_i          in  1                 clock
//   rst_ni         in  1                 asynchronous active-low reset
//   flush_i        in  1                 pipeline flush, drops buffered and offered results
//   fu_result_i    in  NUM_FU results    per-FU completed result
//   fu_ready_o     out NUM_FU            per-FU accept
//   cdb_o          out result            registered CDB broadcast
//   conflict_cnt_o out 32                cycles with two or more buffered results
module cdb_arbiter import ooo_pkg::*; #(
  parameter int NUM_FU     = ooo_pkg::NUM_FU,
  parameter int DATA_WIDTH = ooo_pkg::DATA_WIDTH,
  parameter int ROB_SIZE   = ooo_pkg::ROB_SIZE
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  ooo_pkg::ooo_result_t [NUM_FU-1:0] fu_result_i,
  output logic [NUM_FU-1:0]                fu_ready_o,
  output ooo_pkg::ooo_result_t             cdb_o,
  output logic [31:0]                      conflict_cnt_o
);

  localparam int PtrW = $clog2(NUM_FU);

  // The result record layout is owned by ooo_pkg; these parameters only document it.
  if (DATA_WIDTH != ooo_pkg::DATA_WIDTH || ROB_SIZE != ooo_pkg::ROB_SIZE) begin : g_param_check
    $error("cdb_arbiter: DATA_WIDTH/ROB_SIZE must match ooo_pkg");
  end

  ooo_pkg::ooo_result_t [NUM_FU-1:0] buf_q;
  logic [NUM_FU-1:0]                 buf_valid;
  logic [PtrW-1:0]                   rr_ptr;
  logic [NUM_FU-1:0]                 grant;
  logic [PtrW-1:0]                   grant_idx;
  logic                              grant_any;
  logic                              conflict;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req       (buf_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_any = |grant;
  assign conflict  = $countones(buf_valid) >= 2;

  // Grant comes only from registered state, so ready never depends on fu valid.
  assign fu_ready_o = ~buf_valid | grant;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q          <= '0;
      buf_valid      <= '0;
      rr_ptr         <= '0;
      cdb_o          <= '0;
      conflict_cnt_o <= '0;
    end else if (flush_i) begin
      buf_valid   <= '0;
      cdb_o.valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        // A refill of a draining buffer wins; the old entry leaves via cdb_o below.
        if (fu_result_i[i].valid && fu_ready_o[i]) begin
          buf_valid[i] <= 1'b1;
          buf_q[i]     <= fu_result_i[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end

      if (grant_any) begin
        cdb_o       <= buf_q[grant_idx];
        cdb_o.valid <= 1'b1;
        rr_ptr      <= (grant_idx == PtrW'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        cdb_o.valid <= 1'b0;
      end

      if (conflict) conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end

endmodule
